ysyx_22050598_cache_repl_ctrl: RTL

//   Write-side controller for the per-set 2-bit replacement table of the 4-way D/I cache.

---
 rtl/ysyx_22050598_cache_repl_ctrl_pkg.sv | 34 +++
 rtl/ysyx_22050598_victim_pick.sv | 19 +
 rtl/ysyx_22050598_cache_repl_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ysyx_22050598_cache_repl_ctrl_pkg.sv
// Shared definitions for the replacement-pointer controller: cache geometry,
// FSM state encodings, the captured lookup record and the pointer-advance helper.
// Optional statistics counters are enabled by defining YSYX_22050598_REPL_STATS_EN.
package ysyx_22050598_cache_repl_ctrl_pkg;

  localparam int SETS  = 64;
  localparam int SET_W = 6;
  localparam int WAYS  = 4;
  localparam int WAY_W = 2;

  localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_VICTIM = 3'd2,
    ST_REFILL = 3'd3,
    ST_UPDATE = 3'd4
  } state_e;

  // Lookup result as captured on the accepting edge.
  typedef struct packed {
    logic [SET_W-1:0] set;
    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic [WAYS-1:0]  way_vld;
  } req_t;

  // Round-robin advance; 2-bit arithmetic wraps 3 -> 0.
  function automatic logic [WAY_W-1:0] ptr_next(input logic [WAY_W-1:0] p);
    return p + 2'd1;
  endfunction

endpackage

// File: rtl/ysyx_22050598_victim_pick.sv
// Victim selection: the lowest-index invalid way wins, otherwise the stored
// round-robin pointer names the victim.
module ysyx_22050598_victim_pick
  import ysyx_22050598_cache_repl_ctrl_pkg::*;
(
  input  logic [WAYS-1:0]  way_vld,
  input  logic [WAY_W-1:0] ptr,
  output logic [WAY_W-1:0] victim
);

  // Scan from the top so the lowest invalid index is the last assignment.
  always_comb begin
    victim = ptr;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!way_vld[i]) victim = WAY_W'(i);
    end
  end

endmodule

// File: rtl/ysyx_22050598_cache_repl_ctrl.sv
// Replacement-pointer write controller for the 4-way cache. Accepts lookup
// results, reads the per-set pointer, advances it on a hit to the pointed way,
// and on a miss offers a victim to the refill engine, then writes victim+1 back.
// Define YSYX_22050598_REPL_STATS_EN to build the saturating hit/miss counters;
// otherwise stat_hit/stat_miss are tied to zero.
module ysyx_22050598_cache_repl_ctrl
  import ysyx_22050598_cache_repl_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SET_W-1:0] req_set,
  input  logic             req_hit,
  input  logic [WAY_W-1:0] req_hit_way,
  input  logic [WAYS-1:0]  req_way_vld,
  output logic [SET_W-1:0] tbl_set,
  input  logic [WAY_W-1:0] tbl_ptr_rd,
  output logic             tbl_wen,
  output logic [WAY_W-1:0] tbl_ptr_wr,
  output logic             vic_valid,
  input  logic             vic_ready,
  output logic [SET_W-1:0] vic_set,
  output logic [WAY_W-1:0] vic_way,
  input  logic             refill_done,
  output logic [31:0]      stat_hit,
  output logic [31:0]      stat_miss
);

  state_e           state_q, state_d;
  req_t             cap_q;
  logic [WAY_W-1:0] victim_q;
  logic [WAY_W-1:0] pick;
  logic             accept;

  assign accept    = req_valid && req_ready;
  assign req_ready = (state_q == ST_IDLE);
  // Decoded straight from state so an async reset drops the offer at once.
  assign vic_valid = (state_q == ST_VICTIM);
  assign tbl_set   = cap_q.set;
  assign vic_set   = cap_q.set;
  assign vic_way   = victim_q;

  ysyx_22050598_victim_pick u_pick (
    .way_vld (cap_q.way_vld),
    .ptr     (tbl_ptr_rd),
    .victim  (pick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Capture the lookup result on acceptance; held until the next request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        cap_q <= '0;
    else if (accept) cap_q <= '{set: req_set, hit: req_hit,
                                hit_way: req_hit_way, way_vld: req_way_vld};
  end

  // Victim is registered in LOOKUP so vic_way stays stable while the table read
  // address is reused later for the write-back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                    victim_q <= '0;
    else if (state_q == ST_LOOKUP && !cap_q.hit) victim_q <= pick;
  end

  // Next-state and table write strobes.
  always_comb begin
    state_d    = state_q;
    tbl_wen    = 1'b0;
    tbl_ptr_wr = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (cap_q.hit) begin
          // Only a hit on the pointed way moves the pointer on.
          if (cap_q.hit_way == tbl_ptr_rd) begin
            tbl_wen    = 1'b1;
            tbl_ptr_wr = ptr_next(tbl_ptr_rd);
          end
          state_d = ST_IDLE;
        end else begin
          state_d = ST_VICTIM;
        end
      end
      ST_VICTIM: begin
        if (vic_ready) state_d = ST_REFILL;
      end
      ST_REFILL: begin
        if (refill_done) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        tbl_wen    = 1'b1;
        tbl_ptr_wr = ptr_next(victim_q);
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef YSYX_22050598_REPL_STATS_EN
  logic [31:0] hit_q, miss_q;

  // Saturating hit/miss counters, bumped once per lookup.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state_q == ST_LOOKUP) begin
      if (cap_q.hit  && hit_q  != STAT_MAX) hit_q  <= hit_q + 32'd1;
      if (!cap_q.hit && miss_q != STAT_MAX) miss_q <= miss_q + 32'd1;
    end
  end

  assign stat_hit  = hit_q;
  assign stat_miss = miss_q;
`else
  assign stat_hit  = '0;
  assign stat_miss = '0;
`endif

endmodule
